// File: rtl/branch_pc_unit.sv
// Program counter with beqz branch resolution, one-cycle flush and stall hold.
// Optional taken-branch statistics counter enabled by macro BRANCH_STATS_EN.
module branch_pc_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned PC_STEP  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        is_beqz,
    input  logic [15:0] a0_value,
    input  logic [15:0] branch_target,
    input  logic        stall,
    output logic [15:0] pc,
    output logic        pc_valid,
    output logic        flush,
    output logic        sel
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0] taken_count
`endif
);

    localparam int unsigned PC_W   = 16;
    localparam logic [PC_W-1:0] PC_INC = PC_W'(PC_STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state;

    logic a0_zero_c;
    logic beqz_eval_c;
    logic taken_c;

    // A beqz is only evaluated in RUN on an unstalled cycle.
    assign a0_zero_c   = (a0_value == 16'h0000);
    assign beqz_eval_c = (state == RUN) && in_valid && is_beqz && !stall;
    assign taken_c     = beqz_eval_c && a0_zero_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            pc_valid <= 1'b0;
            flush    <= 1'b0;
            sel      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= RUN;
                    pc_valid <= 1'b1;
                    flush    <= 1'b0;
                end
                RUN: begin
                    if (!stall) begin
                        if (taken_c) begin
                            pc       <= branch_target;
                            sel      <= 1'b1;
                            flush    <= 1'b1;
                            pc_valid <= 1'b0;
                            state    <= FLUSH;
                        end else begin
                            pc <= PC_W'(pc + PC_INC);
                            if (beqz_eval_c) begin
                                sel <= 1'b0;
                            end
                        end
                    end
                end
                FLUSH: begin
                    // Squash lasts one cycle even under stall; pc holds at the target.
                    flush    <= 1'b0;
                    pc_valid <= 1'b1;
                    state    <= RUN;
                end
                default: begin
                    state    <= IDLE;
                    pc_valid <= 1'b0;
                    flush    <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    // Saturating count of taken branches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_count <= 16'h0000;
        end else if (taken_c && (taken_count != 16'hFFFF)) begin
            taken_count <= 16'(taken_count + 16'd1);
        end
    end
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed table-driven bench for branch_pc_unit plus a reset-during-flush sequence.
module tb_branch_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        is_beqz;
    logic [15:0] a0_value;
    logic [15:0] branch_target;
    logic        stall;
    logic [15:0] pc;
    logic        pc_valid;
    logic        flush;
    logic        sel;
`ifdef BRANCH_STATS_EN
    logic [15:0] taken_count;
`endif

    int errors = 0;
    int checks = 0;

    branch_pc_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .is_beqz       (is_beqz),
        .a0_value      (a0_value),
        .branch_target (branch_target),
        .stall         (stall),
        .pc            (pc),
        .pc_valid      (pc_valid),
        .flush         (flush),
        .sel           (sel)
`ifdef BRANCH_STATS_EN
        ,
        .taken_count   (taken_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic        bq;
        logic [15:0] a0;
        logic [15:0] tgt;
        logic        st;
        logic [15:0] e_pc;
        logic        e_val;
        logic        e_fl;
        logic        e_sel;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [15:0] e_pc, input logic e_val,
                            input logic e_fl, input logic e_sel);
        chk({tag, ".pc"},       pc,              e_pc);
        chk({tag, ".pc_valid"}, 16'(pc_valid),   16'(e_val));
        chk({tag, ".flush"},    16'(flush),      16'(e_fl));
        chk({tag, ".sel"},      16'(sel),        16'(e_sel));
    endtask

    task automatic drive(input logic iv, input logic bq, input logic [15:0] a0,
                         input logic [15:0] tgt, input logic st);
        in_valid      = iv;
        is_beqz       = bq;
        a0_value      = a0;
        branch_target = tgt;
        stall         = st;
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //                iv    bq    a0        tgt       st    pc        val   fl    sel
        vecs.push_back('{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0}); // IDLE->RUN
        vecs.push_back('{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 16'h0000, 16'h0040, 1'b0, 16'h0040, 1'b0, 1'b1, 1'b1}); // taken
        vecs.push_back('{1'b1, 1'b1, 16'h0000, 16'h0099, 1'b0, 16'h0040, 1'b1, 1'b0, 1'b1}); // FLUSH ignores beqz
        vecs.push_back('{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0041, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 16'h0005, 16'h0080, 1'b0, 16'h0042, 1'b1, 1'b0, 1'b0}); // not taken
        vecs.push_back('{1'b1, 1'b1, 16'h0000, 16'h0010, 1'b1, 16'h0042, 1'b1, 1'b0, 1'b0}); // stalled
        vecs.push_back('{1'b1, 1'b1, 16'h0000, 16'h0010, 1'b1, 16'h0042, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 16'h0000, 16'h0010, 1'b1, 16'h0042, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 16'h0000, 16'h0010, 1'b0, 16'h0010, 1'b0, 1'b1, 1'b1}); // taken after stall
        vecs.push_back('{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0010, 1'b1, 1'b0, 1'b1}); // FLUSH under stall
        vecs.push_back('{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0011, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 16'h0000, 16'h0077, 1'b0, 16'h0012, 1'b1, 1'b0, 1'b1}); // in_valid=0
        vecs.push_back('{1'b1, 1'b1, 16'h0000, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b1}); // taken to FFFF
        vecs.push_back('{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1}); // wrap
        vecs.push_back('{1'b1, 1'b1, 16'h8000, 16'h0033, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0}); // not taken

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
`ifdef BRANCH_STATS_EN
        chk("reset.taken_count", taken_count, 16'h0000);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].iv, vecs[i].bq, vecs[i].a0, vecs[i].tgt, vecs[i].st);
            @(posedge clk);
            #1;
            chk_outs($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_val, vecs[i].e_fl, vecs[i].e_sel);
        end
`ifdef BRANCH_STATS_EN
        chk("stats.taken_count", taken_count, 16'h0003);
`endif

        // Reset asserted mid-flush must clear everything at once and leave no pulse.
        drive(1'b1, 1'b1, 16'h0000, 16'h0020, 1'b0);
        @(posedge clk);
        #1;
        chk_outs("pre_rst_flush", 16'h0020, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_outs("async_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
`ifdef BRANCH_STATS_EN
        chk("async_rst.taken_count", taken_count, 16'h0000);
`endif
        @(posedge clk);
        #1;
        chk_outs("rst_held", 16'h0000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_outs("post_rst0", 16'h0000, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_outs("post_rst1", 16'h0001, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_pc_unit.md
BRANCH_PC_UNIT -- requirements
Module: branch_pc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 SHALL have parameter PC_STEP, default 1, sequential PC increment in words.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  instruction at current pc is decoded and valid.
REQ-006 SHALL have port is_beqz  input  1  decoded instruction is branch-if-a0-equals-zero.
REQ-007 SHALL have port a0_value  input  16  current contents of register a0.
REQ-008 SHALL have port branch_target  input  16  branch destination address.
REQ-009 SHALL have port stall  input  1  downstream hold request.
REQ-010 SHALL have port pc  output  16  registered program counter.
REQ-011 SHALL have port pc_valid  output  1  pc addresses a live instruction.
REQ-012 SHALL have port flush  output  1  one-cycle squash of the in-flight instruction.
REQ-013 SHALL have port sel  output  1  registered selector for the downstream 16-bit 2:1 mux; 1 = branch_target path, 0 = sequential path.
REQ-014 SHALL have port taken_count  output  16  taken-branch counter, present only under BRANCH_STATS_EN.

Function
REQ-015 SHALL compute a0_zero combinationally as (a0_value == 16'h0000).
REQ-016 SHALL implement a state machine with states IDLE, RUN, FLUSH.
REQ-017 SHALL move IDLE->RUN on the first clock after reset deassertion, with pc unchanged and pc_valid rising to 1.
REQ-018 In RUN with stall=0 and no taken branch, SHALL update pc <= pc + PC_STEP modulo 2^16; 16'hFFFF + 1 wraps to 16'h0000.
REQ-019 A branch is taken when in_valid=1, is_beqz=1, stall=0, a0_zero=1, and state=RUN.
REQ-020 On a taken branch SHALL, at the next edge, load pc <= branch_target, set sel=1, flush=1, pc_valid=0, and enter FLUSH.
REQ-021 A not-taken beqz (a0_zero=0) SHALL set sel=0 and increment pc per REQ-018 with no flush.
REQ-022 Sel SHALL update only on a beqz evaluation in RUN with stall=0 and otherwise hold.
REQ-023 FLUSH SHALL last exactly one cycle regardless of stall, then return to RUN with flush=0 and pc_valid=1; pc SHALL hold during FLUSH.
REQ-024 In FLUSH, in_valid and is_beqz SHALL be ignored.
REQ-025 In RUN with stall=1, pc, sel, pc_valid and state SHALL hold; a beqz presented under stall SHALL NOT be evaluated.
REQ-026 Branch latency SHALL be one cycle to pc update and two cycles until pc_valid=1 at the target.

Reset
REQ-027 rst_n=0 SHALL force, asynchronously: pc=RESET_PC, pc_valid=0, flush=0, sel=0, state=IDLE, taken_count=0.
REQ-028 Reset asserted during FLUSH SHALL abandon the flush immediately with no residual pulse after release.

Configuration
REQ-029 With macro BRANCH_STATS_EN defined, taken_count SHALL increment by 1 on each taken branch and saturate at 16'hFFFF.
REQ-030 Without BRANCH_STATS_EN, the taken_count port and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Reset release, RESET_PC=0, stall=0, no branches -> pc_valid=1 next cycle; pc goes 0,1,2,3 on consecutive cycles.
REQ-032 Branch: beqz, a0_value=0, branch_target=16'h0040 -> next cycle pc=16'h0040, sel=1, flush=1, pc_valid=0; following cycle flush=0, pc_valid=1; then pc=16'h0041.
REQ-033 Not-taken branch: beqz, a0_value=16'h0005 -> sel=0, flush stays 0, pc increments by 1.
REQ-034 Stall: stall=1 for 3 cycles with beqz, a0=0 presented -> pc, sel hold and no branch; after stall drops, the branch is taken on the first unstalled cycle.
REQ-035 Wrap and reset: pc=16'hFFFF -> next pc=16'h0000; rst_n pulsed low during FLUSH -> outputs immediately at reset values, no flush after release.
REQ-036 With BRANCH_STATS_EN defined, 3 taken and 2 not-taken branches -> taken_count=3; preloaded at 16'hFFFF, a taken branch leaves it at 16'hFFFF.
